// File: rtl/ct_f_spsram_2048x88_ctrl.sv
// ct_f_spsram_2048x88_ctrl: valid/ready write and read front-end for a 2048x88 single-port SRAM,
// with conflict-only round-robin arbitration and a 2-entry read response buffer.
// Optional power-up zero-fill sequencer is enabled by defining CT_SPSRAM_CTRL_INIT_EN.
module ct_f_spsram_2048x88_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 88
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  wr_vld,
    output logic                  wr_rdy,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_bwen,
    input  logic                  rd_vld,
    output logic                  rd_rdy,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_resp_vld,
    input  logic                  rd_resp_rdy,
    output logic [DATA_WIDTH-1:0] rd_resp_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    localparam logic PRIO_WR = 1'b0;
    localparam logic PRIO_RD = 1'b1;

    logic                  r_prio;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_cnt;

    logic                  w_init_done;
    logic                  w_init_wr;
    logic [ADDR_WIDTH-1:0] w_init_addr;
    logic                  w_pop;
    logic [2:0]            w_credit;
    logic                  w_rd_ok;
    logic                  w_el_wr;
    logic                  w_el_rd;
    logic                  w_gnt_wr;
    logic                  w_gnt_rd;

`ifdef CT_SPSRAM_CTRL_INIT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] INIT_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_init_addr;
    logic                  r_init_done;

    // Zero-fill sequencer: one write per cycle, then hand the port over to traffic
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state     <= ST_IDLE;
            r_init_addr <= {(ADDR_WIDTH+1){1'b0}};
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_INIT;
                    r_init_addr <= {(ADDR_WIDTH+1){1'b0}};
                    r_init_done <= 1'b0;
                end
                ST_INIT: begin
                    if (r_init_addr == INIT_LAST) begin
                        r_state     <= ST_DONE;
                        r_init_done <= 1'b1;
                    end else begin
                        r_init_addr <= r_init_addr + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    assign w_init_done = r_init_done;
    assign w_init_wr   = (r_state == ST_INIT);
    assign w_init_addr = r_init_addr[ADDR_WIDTH-1:0];
`else
    assign w_init_done = 1'b1;
    assign w_init_wr   = 1'b0;
    assign w_init_addr = {ADDR_WIDTH{1'b0}};
`endif

    assign init_done    = w_init_done;
    assign rd_resp_vld  = (r_cnt != 2'd0);
    assign rd_resp_data = r_buf[r_rptr];
    assign w_pop        = rd_resp_vld & rd_resp_rdy;

    // A read needs a free slot counting the in-flight beat; a same-cycle pop frees one
    assign w_credit = {2'b00, r_inflight} + {1'b0, r_cnt} - {2'b00, w_pop};
    assign w_rd_ok  = w_init_done & (w_credit < 3'd2);

    assign w_el_wr  = wr_vld & w_init_done;
    assign w_el_rd  = rd_vld & w_rd_ok;
    assign wr_rdy   = w_init_done & (~w_el_rd | (r_prio == PRIO_WR));
    assign rd_rdy   = w_rd_ok & (~w_el_wr | (r_prio == PRIO_RD));
    assign w_gnt_wr = w_el_wr & wr_rdy;
    assign w_gnt_rd = w_el_rd & rd_rdy;

    // SRAM port drive: zero-fill, granted write, granted read, or idle
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = {DATA_WIDTH{1'b1}};
        sram_a    = {ADDR_WIDTH{1'b0}};
        sram_d    = {DATA_WIDTH{1'b0}};
        if (w_init_wr) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = {DATA_WIDTH{1'b0}};
            sram_a    = w_init_addr;
        end else if (w_gnt_wr) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~wr_bwen;
            sram_a    = wr_addr;
            sram_d    = wr_data;
        end else if (w_gnt_rd) begin
            sram_cen  = 1'b0;
            sram_a    = rd_addr;
        end else begin
            sram_cen  = 1'b1;
        end
    end

    // Priority pointer flips only when both channels compete
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_prio <= PRIO_WR;
        end else if (w_el_wr & w_el_rd) begin
            r_prio <= ~r_prio;
        end else begin
            r_prio <= r_prio;
        end
    end

    // In-flight tracking and response FIFO; sram_q is captured the cycle after the read
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_inflight <= 1'b0;
            r_buf[0]   <= {DATA_WIDTH{1'b0}};
            r_buf[1]   <= {DATA_WIDTH{1'b0}};
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            r_inflight <= w_gnt_rd;
            if (r_inflight) begin
                r_buf[r_wptr] <= sram_q;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_ct_f_spsram_2048x88_ctrl.sv
// Bench for ct_f_spsram_2048x88_ctrl: behavioural SRAM, reference memory and a read scoreboard,
// an arbitration vector table, and directed latency/backpressure/reset sequences.
module tb_ct_f_spsram_2048x88_ctrl;
    localparam int AW = 11;
    localparam int DW = 88;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_vld, wr_rdy, rd_vld, rd_rdy;
    logic [AW-1:0] wr_addr, rd_addr, sram_a;
    logic [DW-1:0] wr_data, wr_bwen, rd_resp_data, sram_wen, sram_d;
    logic [DW-1:0] sram_q = '0;
    logic          rd_resp_vld, rd_resp_rdy, init_done, sram_cen, sram_gwen;

    ct_f_spsram_2048x88_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .forever_cpuclk(clk), .cpurst_b(rst_n),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bwen(wr_bwen),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_addr(rd_addr),
        .rd_resp_vld(rd_resp_vld), .rd_resp_rdy(rd_resp_rdy), .rd_resp_data(rd_resp_data),
        .init_done(init_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc_cnt = 0;
    int            pop_cnt = 0;
    int            rd_fire_cnt = 0;
    int            last_pop_cyc = 0;
    logic [DW-1:0] last_pop_data = '0;
    logic [DW-1:0] sram_mem [2**AW];
    logic [DW-1:0] ref_mem [2**AW];
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural SRAM macro: active-low enables, 1-cycle read latency
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (!sram_cen) begin
            if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= sram_mem[sram_a];
        end
    end

    // Monitor: reference memory, scoreboard push on read accept, pop/compare on response
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst_n) begin
            if (rd_resp_vld && rd_resp_rdy) begin
                if (exp_q.size() == 0) begin
                    chkb("resp_unexpected", rd_resp_vld, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", rd_resp_data, e);
                end
                pop_cnt++;
                last_pop_cyc = cyc_cnt;
                last_pop_data = rd_resp_data;
            end
            if (init_done) begin
                chkb("wr_access_match", !sram_cen && !sram_gwen, wr_vld && wr_rdy);
                chkb("rd_access_match", !sram_cen && sram_gwen, rd_vld && rd_rdy);
            end
            if (wr_vld && wr_rdy) begin
                chki("wr_port_addr", int'(sram_a), int'(wr_addr));
                chk("wr_port_wen", sram_wen, ~wr_bwen);
                chk("wr_port_d", sram_d, wr_data);
                ref_mem[wr_addr] = (ref_mem[wr_addr] & ~wr_bwen) | (wr_data & wr_bwen);
            end
            if (rd_vld && rd_rdy) begin
                chki("rd_port_addr", int'(sram_a), int'(rd_addr));
                exp_q.push_back(ref_mem[rd_addr]);
                rd_fire_cnt++;
                chkb("sb_depth_le2", exp_q.size() <= 2, 1'b1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_vld = 1'b0; rd_vld = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_bwen = '0;
    endtask

    task automatic assert_rst();
        rst_n = 1'b0;
        idle();
        exp_q.delete();
`ifdef CT_SPSRAM_CTRL_INIT_EN
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
`endif
    endtask

    task automatic release_rst();
        repeat (3) cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_init();
        int n = 0;
        while (n < 2100) begin
            cyc();
            n++;
            if (n == 1) begin
                chki("init_first_addr", int'(sram_a), 0);
                chkb("init_cen", sram_cen, 1'b0);
                chkb("init_gwen", sram_gwen, 1'b0);
                chk("init_wen", sram_wen, '0);
                chkb("init_wr_rdy", wr_rdy, 1'b0);
                chkb("init_rd_rdy", rd_rdy, 1'b0);
            end
            if (init_done) break;
        end
        chki("init_latency", n, 2049);
    endtask

    task automatic wr_one(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] be);
        logic ok = 1'b0;
        wr_vld = 1'b1; wr_addr = a; wr_data = d; wr_bwen = be;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            ok = wr_rdy;
            cyc();
            if (ok) break;
        end
        chkb("wr_accept", ok, 1'b1);
        wr_vld = 1'b0;
    endtask

    task automatic rd_one(input logic [AW-1:0] a);
        logic ok = 1'b0;
        rd_vld = 1'b1; rd_addr = a;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            ok = rd_rdy;
            cyc();
            if (ok) break;
        end
        chkb("rd_accept", ok, 1'b1);
        rd_vld = 1'b0;
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (pop_cnt < target && n < 50) begin
            cyc();
            n++;
        end
        chkb("resp_arrived", pop_cnt >= target, 1'b1);
    endtask

    typedef struct {
        logic          wv;
        logic          rv;
        logic [AW-1:0] waddr;
        logic [AW-1:0] raddr;
        logic [DW-1:0] wdata;
        logic          e_wrdy;
        logic          e_rrdy;
        logic          e_cen;
        logic          e_gwen;
        logic [AW-1:0] e_a;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, c0, f0;
        for (int i = 0; i < 2**AW; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        rd_resp_rdy = 1'b1;
        assert_rst();
        release_rst();

        @(negedge clk);
        chkb("rst_resp_vld", rd_resp_vld, 1'b0);
        chk("rst_resp_data", rd_resp_data, '0);
        chkb("rst_cen", sram_cen, 1'b1);
        chkb("rst_gwen", sram_gwen, 1'b1);
        chk("rst_wen", sram_wen, {DW{1'b1}});
`ifdef CT_SPSRAM_CTRL_INIT_EN
        chkb("rst_init_done", init_done, 1'b0);
        wait_init();
        p0 = pop_cnt;
        rd_one(11'h7FF);
        wait_pops(p0 + 1);
        chk("init_rd_7ff", last_pop_data, '0);
`else
        chkb("rst_init_done", init_done, 1'b1);
        cyc();
`endif

        // Arbitration table: priority starts at write and flips only on conflicts
        tbl[0] = '{1'b1, 1'b0, 11'h010, 11'h000, '0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h010};
        tbl[1] = '{1'b0, 1'b1, 11'h000, 11'h010, '0, 1'b1, 1'b1, 1'b0, 1'b1, 11'h010};
        tbl[2] = '{1'b1, 1'b1, 11'h011, 11'h010, '0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h011};
        tbl[3] = '{1'b1, 1'b1, 11'h012, 11'h011, '0, 1'b0, 1'b1, 1'b0, 1'b1, 11'h011};
        tbl[4] = '{1'b1, 1'b1, 11'h012, 11'h011, '0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h012};
        tbl[5] = '{1'b1, 1'b1, 11'h013, 11'h012, '0, 1'b0, 1'b1, 1'b0, 1'b1, 11'h012};
        tbl[6] = '{1'b1, 1'b1, 11'h013, 11'h012, '0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h013};
        tbl[7] = '{1'b1, 1'b1, 11'h014, 11'h013, '0, 1'b0, 1'b1, 1'b0, 1'b1, 11'h013};
        tbl[8] = '{1'b0, 1'b0, 11'h000, 11'h000, '0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h000};
        for (int i = 0; i < 9; i++) tbl[i].wdata = {8{11'(i + 1)}};

        p0 = pop_cnt;
        for (int i = 0; i < 9; i++) begin
            wr_vld = tbl[i].wv; rd_vld = tbl[i].rv;
            wr_addr = tbl[i].waddr; rd_addr = tbl[i].raddr;
            wr_data = tbl[i].wdata; wr_bwen = {DW{1'b1}};
            @(negedge clk);
            chkb("tbl_wr_rdy", wr_rdy, tbl[i].e_wrdy);
            chkb("tbl_rd_rdy", rd_rdy, tbl[i].e_rrdy);
            chkb("tbl_cen", sram_cen, tbl[i].e_cen);
            chkb("tbl_gwen", sram_gwen, tbl[i].e_gwen);
            if (!tbl[i].e_cen) chki("tbl_addr", int'(sram_a), int'(tbl[i].e_a));
            cyc();
        end
        idle();
        wait_pops(p0 + 4);

        // Full write then read: response visible two cycles after the accept
        wr_one(11'h003, {11{8'h5A}}, {DW{1'b1}});
        rd_vld = 1'b1; rd_addr = 11'h003;
        @(negedge clk);
        chkb("lat_rd_rdy", rd_rdy, 1'b1);
        cyc();
        rd_vld = 1'b0;
        @(negedge clk);
        chkb("lat_n1_vld", rd_resp_vld, 1'b0);
        cyc();
        @(negedge clk);
        chkb("lat_n2_vld", rd_resp_vld, 1'b1);
        chk("lat_n2_data", rd_resp_data, {11{8'h5A}});
        cyc();

        // Partial write: only the low byte changes
        wr_one(11'h003, {11{8'hC3}}, {{80{1'b0}}, 8'hFF});
        p0 = pop_cnt;
        rd_one(11'h003);
        wait_pops(p0 + 1);
        chk("partial_wr", last_pop_data, {{10{8'h5A}}, 8'hC3});

        // Eight back-to-back reads at full throughput
        p0 = pop_cnt;
        c0 = 0;
        for (int i = 0; i < 8; i++) begin
            rd_vld = 1'b1; rd_addr = 11'(16 + i);
            @(negedge clk);
            if (i == 0) c0 = cyc_cnt;
            chkb("b2b_rd_rdy", rd_rdy, 1'b1);
            cyc();
        end
        rd_vld = 1'b0;
        wait_pops(p0 + 8);
        repeat (3) cyc();
        chki("b2b_count", pop_cnt - p0, 8);
        chki("b2b_last_cycle", last_pop_cyc, c0 + 9);

        // Backpressure: only two reads may be outstanding
        rd_resp_rdy = 1'b0;
        p0 = pop_cnt;
        f0 = rd_fire_cnt;
        rd_vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd_addr = 11'(16 + i);
            cyc();
        end
        @(negedge clk);
        chki("bp_accepted", rd_fire_cnt - f0, 2);
        chkb("bp_rd_rdy", rd_rdy, 1'b0);
        chkb("bp_resp_vld", rd_resp_vld, 1'b1);
        chkb("bp_no_access", sram_cen, 1'b1);
        cyc();
        rd_resp_rdy = 1'b1;
        @(negedge clk);
        chkb("bp_pop_frees", rd_rdy, 1'b1);
        cyc();
        rd_vld = 1'b0;
        wait_pops(p0 + 3);

        // Reset with a buffered and an in-flight read
        rd_resp_rdy = 1'b0;
        rd_vld = 1'b1; rd_addr = 11'h005;
        cyc();
        cyc();
        assert_rst();
        #1;
        chkb("midrst_resp_vld", rd_resp_vld, 1'b0);
        chk("midrst_resp_data", rd_resp_data, '0);
        release_rst();
        rd_resp_rdy = 1'b1;
        @(negedge clk);
        chkb("midrst_cen", sram_cen, 1'b1);
        chkb("midrst_resp_vld2", rd_resp_vld, 1'b0);
`ifdef CT_SPSRAM_CTRL_INIT_EN
        wait_init();
`else
        cyc();
`endif
        p0 = pop_cnt;
        rd_one(11'h003);
        wait_pops(p0 + 1);
        repeat (2) cyc();
        chki("midrst_pops", pop_cnt - p0, 1);

`ifdef CT_SPSRAM_CTRL_INIT_EN
        // Reset in the middle of zero-fill restarts the address counter
        assert_rst();
        release_rst();
        repeat (100) cyc();
        assert_rst();
        #1;
        chkb("initrst_done", init_done, 1'b0);
        release_rst();
        wait_init();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
